// File: rtl/pic_pkg.sv
// Shared definitions for the 8259-style PIC control path.
// Holds the INTA sequencer FSM encoding, the spurious vector level,
// the reset value of last_serviced, and one-hot <-> index helpers
// that both the resolver and the sequencer use.
// No ports (package).
package pic_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_ACK1  = 3'd2,
        ST_WAIT2 = 3'd3,
        ST_ACK2  = 3'd4
    } state_e;

    localparam logic [2:0] SPURIOUS_LEVEL    = 3'd7;
    localparam logic [7:0] LAST_SERVICED_RST = 8'h80;

    // Index of the lowest set bit; 0 when nothing is set.
    function automatic logic [2:0] onehot2idx(input logic [7:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int i = 7; i >= 0; i--) begin
            if (oh[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    function automatic logic [7:0] idx2onehot(input logic [2:0] idx);
        return 8'b1 << idx;
    endfunction

endpackage

// File: rtl/isr_highest_pick.sv
// Combinational selector of the highest-priority In-Service bit.
// Priority rotates: the level just after last_serviced is highest,
// wrapping round, so last_serviced itself is lowest.
// Ports:
//   is_status_i      in  8  current ISR contents
//   last_serviced_i  in  8  one-hot, last level cleared by EOI
//   pick_o           out 8  one-hot of the winning ISR bit, 0 if ISR empty
module isr_highest_pick
    import pic_pkg::*;
(
    input  logic [7:0] is_status_i,
    input  logic [7:0] last_serviced_i,
    output logic [7:0] pick_o
);

    logic [2:0] last_idx;
    logic [2:0] idx;
    logic       found;

    always_comb begin
        pick_o   = '0;
        found    = 1'b0;
        idx      = '0;
        last_idx = onehot2idx(last_serviced_i);
        // Walk k = 1..8 positions past last_serviced; k = 8 wraps onto itself.
        for (int k = 1; k <= 8; k++) begin
            idx = last_idx + 3'(k);
            if (!found && is_status_i[idx]) begin
                pick_o = idx2onehot(idx);
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/inta_sequencer.sv
// INTA sequencer of the 8259 PIC: raises INT for the resolver's winner,
// runs the two-pulse 8086 acknowledge, owns the ISR, drives the vector
// and executes EOI commands.
// Optional feature: define AEOI_EN to add aeoi_mode (automatic EOI at
// the end of the second INTA pulse).
// Ports:
//   clk, rst_n      clock / asynchronous active-low reset
//   priority_i  8   one-hot winner from resolver (0 = none)
//   inta_n      1   CPU acknowledge, active-low, asynchronous
//   icw2_base   5   vector base T7..T3
//   rotate_on_eoi 1 update last_serviced on each effective EOI
//   eoi_cmd, eoi_specific, eoi_level  EOI command strobe and operands
//   aeoi_mode   1   (AEOI_EN only) automatic EOI enable
//   int_o       1   interrupt request to CPU
//   is_status   8   ISR contents
//   last_serviced 8 one-hot, last level cleared by EOI
//   clr_irr     8   one-cycle pulse clearing the acknowledged IRR bit
//   vector_o    8   {icw2_base, level}
//   vector_oe   1   bus drive enable during the 2nd INTA
module inta_sequencer
    import pic_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] priority_i,
    input  logic       inta_n,
    input  logic [4:0] icw2_base,
    input  logic       rotate_on_eoi,
    input  logic       eoi_cmd,
    input  logic       eoi_specific,
    input  logic [2:0] eoi_level,
`ifdef AEOI_EN
    input  logic       aeoi_mode,
`endif
    output logic       int_o,
    output logic [7:0] is_status,
    output logic [7:0] last_serviced,
    output logic [7:0] clr_irr,
    output logic [7:0] vector_o,
    output logic       vector_oe
);

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] inta_sync_q;
    logic                   inta_prev_q;
    logic                   inta_fall, inta_rise;

    logic [2:0] level_q, level_d;
    logic       int_q, int_d;
    logic [7:0] isr_q, isr_d;
    logic [7:0] last_q, last_d;
    logic [7:0] clr_q, clr_d;
    logic [7:0] vec_q, vec_d;
    logic       vec_oe_q, vec_oe_d;

    logic [7:0] set_mask, eoi_mask, aeoi_mask, nsp_pick;
    logic [7:0] eoi_cleared, aeoi_cleared;

    // Edges are taken on the last synchroniser flop against one more flop,
    // so the registered action lands SYNC_STAGES+1 clocks after the pin.
    assign inta_fall = inta_prev_q & ~inta_sync_q[SYNC_STAGES-1];
    assign inta_rise = ~inta_prev_q & inta_sync_q[SYNC_STAGES-1];

    isr_highest_pick u_pick (
        .is_status_i     (isr_q),
        .last_serviced_i (last_q),
        .pick_o          (nsp_pick)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (priority_i != '0) state_d = ST_REQ;
            ST_REQ: begin
                // A fall wins over a vanished request: that is the spurious case.
                if (inta_fall)               state_d = ST_ACK1;
                else if (priority_i == '0)   state_d = ST_IDLE;
            end
            ST_ACK1:  if (inta_rise) state_d = ST_WAIT2;
            ST_WAIT2: if (inta_fall) state_d = ST_ACK2;
            ST_ACK2:  if (inta_rise) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

`ifdef AEOI_EN
    logic spurious_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spurious_q <= 1'b0;
        end else if (state_q == ST_REQ && inta_fall) begin
            spurious_q <= (priority_i == '0);
        end
    end
`endif

    // Output / datapath next values
    always_comb begin
        level_d   = level_q;
        int_d     = (state_d == ST_REQ);
        set_mask  = '0;
        vec_d     = vec_q;
        vec_oe_d  = vec_oe_q;
        eoi_mask  = '0;
        aeoi_mask = '0;

        if (state_q == ST_REQ && inta_fall) begin
            if (priority_i == '0) begin
                level_d = SPURIOUS_LEVEL;
            end else begin
                level_d  = onehot2idx(priority_i);
                set_mask = idx2onehot(level_d);
            end
        end
        clr_d = set_mask;

        if (state_q == ST_WAIT2 && inta_fall) begin
            vec_d    = {icw2_base, level_q};
            vec_oe_d = 1'b1;
        end
        if (state_q == ST_ACK2 && inta_rise) begin
            vec_oe_d = 1'b0;
`ifdef AEOI_EN
            if (aeoi_mode && !spurious_q) aeoi_mask = idx2onehot(level_q);
`endif
        end

        if (eoi_cmd) begin
            eoi_mask = eoi_specific ? idx2onehot(eoi_level) : nsp_pick;
        end

        // A bit being set this cycle is not counted as cleared: set wins.
        eoi_cleared  = eoi_mask  & isr_q & ~set_mask;
        aeoi_cleared = aeoi_mask & isr_q & ~set_mask;
        isr_d = (isr_q & ~(eoi_mask | aeoi_mask)) | set_mask;

        last_d = last_q;
        if (rotate_on_eoi) begin
            if (eoi_cleared != '0)       last_d = eoi_cleared;
            else if (aeoi_cleared != '0) last_d = aeoi_cleared;
        end
    end

    // Output and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inta_sync_q <= '1;
            inta_prev_q <= 1'b1;
            level_q     <= '0;
            int_q       <= 1'b0;
            isr_q       <= '0;
            last_q      <= LAST_SERVICED_RST;
            clr_q       <= '0;
            vec_q       <= '0;
            vec_oe_q    <= 1'b0;
        end else begin
            inta_sync_q <= {inta_sync_q[SYNC_STAGES-2:0], inta_n};
            inta_prev_q <= inta_sync_q[SYNC_STAGES-1];
            level_q     <= level_d;
            int_q       <= int_d;
            isr_q       <= isr_d;
            last_q      <= last_d;
            clr_q       <= clr_d;
            vec_q       <= vec_d;
            vec_oe_q    <= vec_oe_d;
        end
    end

    assign int_o         = int_q;
    assign is_status     = isr_q;
    assign last_serviced = last_q;
    assign clr_irr       = clr_q;
    assign vector_o      = vec_q;
    assign vector_oe     = vec_oe_q;

endmodule

// File: tb/tb_inta_sequencer.sv
// Directed plus randomized bench for inta_sequencer with a transaction-level
// model of the ISR and the rotating last_serviced level.
module tb_inta_sequencer;

    localparam int SYNC = 2;
    localparam int LAT  = SYNC + 1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] priority_i;
    logic       inta_n;
    logic [4:0] icw2_base;
    logic       rotate_on_eoi;
    logic       eoi_cmd;
    logic       eoi_specific;
    logic [2:0] eoi_level;
`ifdef AEOI_EN
    logic       aeoi_mode;
`endif
    logic       int_o;
    logic [7:0] is_status;
    logic [7:0] last_serviced;
    logic [7:0] clr_irr;
    logic [7:0] vector_o;
    logic       vector_oe;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state
    bit [7:0] m_isr;
    int       m_last;
    bit       m_aeoi;

    always #5 clk = ~clk;

    inta_sequencer #(.SYNC_STAGES(SYNC)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .priority_i    (priority_i),
        .inta_n        (inta_n),
        .icw2_base     (icw2_base),
        .rotate_on_eoi (rotate_on_eoi),
        .eoi_cmd       (eoi_cmd),
        .eoi_specific  (eoi_specific),
        .eoi_level     (eoi_level),
`ifdef AEOI_EN
        .aeoi_mode     (aeoi_mode),
`endif
        .int_o         (int_o),
        .is_status     (is_status),
        .last_serviced (last_serviced),
        .clr_irr       (clr_irr),
        .vector_o      (vector_o),
        .vector_oe     (vector_oe)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit [7:0] oh(input int lvl);
        bit [7:0] r;
        r = '0;
        r[lvl] = 1'b1;
        return r;
    endfunction

    function automatic bit [7:0] m_last_oh();
        return oh(m_last);
    endfunction

    task automatic model_reset();
        m_isr  = '0;
        m_last = 7;
    endtask

    // EOI rule: specific clears the named level if set; non-specific clears
    // the first set level found going round from one past last_serviced.
    task automatic model_eoi(input bit spec, input int lvl, input bit rot);
        int tgt;
        tgt = -1;
        if (spec) begin
            if (m_isr[lvl]) tgt = lvl;
        end else begin
            for (int k = 1; k <= 8; k++) begin
                if (tgt < 0 && m_isr[(m_last + k) % 8]) tgt = (m_last + k) % 8;
            end
        end
        if (tgt >= 0) begin
            m_isr[tgt] = 1'b0;
            if (rot) m_last = tgt;
        end
    endtask

    task automatic do_eoi(input bit spec, input int lvl, input bit rot);
        eoi_cmd       = 1'b1;
        eoi_specific  = spec;
        eoi_level     = 3'(lvl);
        rotate_on_eoi = rot;
        tick(1);
        eoi_cmd = 1'b0;
        model_eoi(spec, lvl, rot);
        check("eoi_isr", is_status, m_isr);
        check("eoi_last", last_serviced, m_last_oh());
    endtask

    // One full two-pulse acknowledge. eoi_same: issue a specific EOI of the
    // same level in the cycle the ISR bit is set.
    task automatic run_seq(input int lvl, input bit spur, input bit [4:0] base,
                           input bit rot, input bit eoi_same);
        int vlvl;
        icw2_base     = base;
        rotate_on_eoi = rot;
        priority_i    = oh(lvl);
        tick(1);
        check("int_raised", {7'b0, int_o}, 8'h01);
        inta_n = 1'b0;
        tick(SYNC);
        if (spur) priority_i = '0;
        if (eoi_same) begin
            eoi_cmd      = 1'b1;
            eoi_specific = 1'b1;
            eoi_level    = 3'(lvl);
        end
        tick(1);
        eoi_cmd = 1'b0;
        vlvl = spur ? 7 : lvl;
        if (!spur) m_isr[lvl] = 1'b1;
        check("ack1_isr", is_status, m_isr);
        check("ack1_clr", clr_irr, spur ? 8'h00 : oh(lvl));
        check("ack1_int", {7'b0, int_o}, 8'h00);
        priority_i = '0;
        tick(1);
        check("clr_pulse_end", clr_irr, 8'h00);
        inta_n = 1'b1;
        tick(LAT);
        inta_n = 1'b0;
        tick(LAT);
        check("ack2_oe", {7'b0, vector_oe}, 8'h01);
        check("ack2_vec", vector_o, {base, 3'(vlvl)});
        inta_n = 1'b1;
        tick(LAT);
        if (m_aeoi && !spur) begin
            m_isr[lvl] = 1'b0;
            if (rot) m_last = lvl;
        end
        check("end_oe", {7'b0, vector_oe}, 8'h00);
        check("end_isr", is_status, m_isr);
        check("end_last", last_serviced, m_last_oh());
    endtask

    initial begin
        rst_n         = 1'b0;
        priority_i    = '0;
        inta_n        = 1'b1;
        icw2_base     = '0;
        rotate_on_eoi = 1'b0;
        eoi_cmd       = 1'b0;
        eoi_specific  = 1'b0;
        eoi_level     = '0;
        m_aeoi        = 1'b0;
`ifdef AEOI_EN
        aeoi_mode     = 1'b0;
`endif
        model_reset();
        tick(2);
        check("rst_int", {7'b0, int_o}, 8'h00);
        check("rst_isr", is_status, 8'h00);
        check("rst_last", last_serviced, 8'h80);
        check("rst_clr", clr_irr, 8'h00);
        check("rst_vec", vector_o, 8'h00);
        check("rst_oe", {7'b0, vector_oe}, 8'h00);
        rst_n = 1'b1;
        tick(2);

        // Two-pulse sequence on IR1, base 0x08 -> vector 0x41
        run_seq(1, 1'b0, 5'h08, 1'b0, 1'b0);
        check("t2_vec_const", vector_o, 8'h41);
        check("t2_isr_const", is_status, 8'h02);

        // Reset in the middle of ACK1
        priority_i = 8'h02;
        tick(1);
        inta_n = 1'b0;
        tick(LAT);
        check("t1_isr_pre", is_status, 8'h02);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("t1_int", {7'b0, int_o}, 8'h00);
        check("t1_isr", is_status, 8'h00);
        check("t1_last", last_serviced, 8'h80);
        check("t1_clr", clr_irr, 8'h00);
        check("t1_vec", vector_o, 8'h00);
        check("t1_oe", {7'b0, vector_oe}, 8'h00);
        priority_i = '0;
        inta_n     = 1'b1;
        tick(2);
        rst_n = 1'b1;
        tick(2);

        // Spurious: request vanishes as the first fall is taken
        run_seq(2, 1'b1, 5'h15, 1'b0, 1'b0);
        check("t3_vec_const", vector_o, {5'h15, 3'd7});
        check("t3_isr_const", is_status, 8'h00);

        // Rotating non-specific EOI: ISR=C0, last=01 -> ISR=80, last=40
        run_seq(0, 1'b0, 5'h01, 1'b1, 1'b0);
        do_eoi(1'b1, 0, 1'b1);
        check("t4_last_pre", last_serviced, 8'h01);
        run_seq(7, 1'b0, 5'h01, 1'b1, 1'b0);
        run_seq(6, 1'b0, 5'h01, 1'b1, 1'b0);
        check("t4_isr_pre", is_status, 8'hC0);
        do_eoi(1'b0, 0, 1'b1);
        check("t4_isr", is_status, 8'h80);
        check("t4_last", last_serviced, 8'h40);

        // Specific EOI on an empty bit, then EOI colliding with the set
        do_eoi(1'b1, 7, 1'b0);
        do_eoi(1'b1, 3, 1'b0);
        check("t5_isr_noop", is_status, 8'h00);
        run_seq(1, 1'b0, 5'h02, 1'b1, 1'b1);
        check("t5_set_wins", is_status, 8'h02);
        check("t5_last_kept", last_serviced, 8'h40);

        // Randomized mix of sequences and EOIs
        for (int it = 0; it < 60; it++) begin
            if ($urandom_range(0, 2) == 0) begin
                run_seq($urandom_range(0, 7), ($urandom_range(0, 7) == 0),
                        5'($urandom), 1'($urandom), 1'b0);
            end else begin
                do_eoi(1'($urandom), $urandom_range(0, 7), 1'($urandom));
            end
        end

`ifdef AEOI_EN
        // Automatic EOI on IR5 with rotation
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        model_reset();
        tick(1);
        aeoi_mode = 1'b1;
        m_aeoi    = 1'b1;
        run_seq(5, 1'b0, 5'h0A, 1'b1, 1'b0);
        check("t6_isr", is_status, 8'h00);
        check("t6_last", last_serviced, 8'h20);
        aeoi_mode = 1'b0;
        m_aeoi    = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
